context_switch_unit: RTL and testbench

- Consumer side of the scheduler's context-switch interface. Takes the switch pulse and next process number from the round-robin scheduler.
- Stalls the CPU, saves the outgoing process's PC and register file into a per-process context store, then restores the incoming process's context.
- Sits between the scheduler and the CPU datapath (register file write/read port and PC load).

---
 rtl/context_switch_unit_if.sv | 32 +++
 rtl/context_switch_unit.sv | 213 +++++++++++++++++++++
 tb/tb_context_switch_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/context_switch_unit_if.sv
// Context-switch unit bus bundle: scheduler request side plus the CPU
// stall / register-file / PC-load side. The unit itself uses the master
// modport; the CPU and scheduler environment use the slave modport.
interface context_switch_unit_if;
    logic        switch_req;
    logic [31:0] next_pid;
    logic        cpu_safe;
    logic [31:0] cpu_pc_in;
    logic [31:0] rf_rdata;
    logic        cpu_stall;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic        rf_we;
    logic        pc_load;
    logic [31:0] pc_value;
    logic [31:0] current_pid;
    logic        busy;
    logic        switch_done;
    logic        err;

    modport master (
        input  switch_req, next_pid, cpu_safe, cpu_pc_in, rf_rdata,
        output cpu_stall, rf_addr, rf_wdata, rf_we, pc_load, pc_value,
               current_pid, busy, switch_done, err
    );

    modport slave (
        output switch_req, next_pid, cpu_safe, cpu_pc_in, rf_rdata,
        input  cpu_stall, rf_addr, rf_wdata, rf_we, pc_load, pc_value,
               current_pid, busy, switch_done, err
    );
endinterface

// File: rtl/context_switch_unit.sv
// Context-switch unit: takes switch requests from the round-robin scheduler,
// stalls the CPU, saves the outgoing process's PC (and, when built with
// CTX_SAVE_REGS_EN, its register file) and restores the incoming context.
// Without CTX_SAVE_REGS_EN only the PC is switched and the register-file
// port is held at zero.
module context_switch_unit #(
    parameter int          NPROC     = 5,
    parameter int          NREGS     = 32,
    parameter logic [31:0] PC_STRIDE = 32'd256
) (
    input logic                   clock,
    input logic                   reset,
    context_switch_unit_if.master bus
);
    localparam int PID_W = (NPROC > 1) ? $clog2(NPROC) : 1;

`ifdef CTX_SAVE_REGS_EN
    localparam int         REG_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        SAVE   = 3'd2,
        LOAD   = 3'd3,
        RESUME = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        RESUME = 3'd4
    } state_t;
`endif

    state_t      state_r;
    logic [31:0] target_r;
    logic [31:0] current_pid_r;
    logic        pending_valid_r;
    logic [31:0] pending_pid_r;
    logic [31:0] pc_table_r [0:NPROC-1];
    logic        cpu_stall_r;
    logic        busy_r;
    logic        pc_load_r;
    logic [31:0] pc_value_r;
    logic        switch_done_r;
    logic        err_r;

    logic             req_s;
    logic [31:0]      req_pid_s;
    logic [PID_W-1:0] cur_idx_s;
    logic [PID_W-1:0] tgt_idx_s;

    // Slot indices are only meaningful once a pid has passed the range check
    assign cur_idx_s = current_pid_r[PID_W-1:0];
    assign tgt_idx_s = target_r[PID_W-1:0];

`ifdef CTX_SAVE_REGS_EN
    logic [4:0]  rf_addr_r;
    logic [31:0] rf_wdata_r;
    logic        rf_we_r;
    logic [4:0]  next_addr_s;
    logic [31:0] ctx_r [0:NPROC-1][0:NREGS-1];

    assign next_addr_s  = rf_addr_r + 5'd1;
    assign bus.rf_addr  = rf_addr_r;
    assign bus.rf_wdata = rf_wdata_r;
    assign bus.rf_we    = rf_we_r;

    // Register context store: one word captured per SAVE cycle, no reset
    always_ff @(posedge clock) begin
        if (state_r == SAVE) begin
            ctx_r[cur_idx_s][rf_addr_r[REG_W-1:0]] <= bus.rf_rdata;
        end
    end
`else
    logic unused_rdata_s;

    assign unused_rdata_s = ^bus.rf_rdata;
    assign bus.rf_addr    = 5'd0;
    assign bus.rf_wdata   = 32'd0;
    assign bus.rf_we      = 1'b0;
`endif

    // Request seen from IDLE: a live pulse is newer than the stored one
    always_comb begin
        req_s     = 1'b0;
        req_pid_s = 32'd0;
        if (bus.switch_req) begin
            req_s     = 1'b1;
            req_pid_s = bus.next_pid;
        end else if (pending_valid_r) begin
            req_s     = 1'b1;
            req_pid_s = pending_pid_r;
        end else begin
            req_s     = 1'b0;
            req_pid_s = 32'd0;
        end
    end

    // Switch sequencer: state, pending slot, PC table and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            target_r        <= 32'd0;
            current_pid_r   <= 32'd0;
            pending_valid_r <= 1'b0;
            pending_pid_r   <= 32'd0;
            cpu_stall_r     <= 1'b0;
            busy_r          <= 1'b0;
            pc_load_r       <= 1'b0;
            pc_value_r      <= 32'd0;
            switch_done_r   <= 1'b0;
            err_r           <= 1'b0;
            for (int i = 0; i < NPROC; i++) begin
                pc_table_r[i] <= 32'(i) * PC_STRIDE;
            end
`ifdef CTX_SAVE_REGS_EN
            rf_addr_r  <= 5'd0;
            rf_wdata_r <= 32'd0;
            rf_we_r    <= 1'b0;
`endif
        end else begin
            pc_load_r     <= 1'b0;
            switch_done_r <= 1'b0;
            err_r         <= 1'b0;

            // Requests arriving mid-switch (RESUME included) wait in the slot
            if (state_r == IDLE) begin
                pending_valid_r <= 1'b0;
            end else if (bus.switch_req) begin
                pending_valid_r <= 1'b1;
                pending_pid_r   <= bus.next_pid;
            end

            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        if (req_pid_s >= 32'(NPROC)) begin
                            err_r <= 1'b1;
                        end else if (req_pid_s == current_pid_r) begin
                            switch_done_r <= 1'b1;
                        end else begin
                            target_r    <= req_pid_s;
                            state_r     <= DRAIN;
                            cpu_stall_r <= 1'b1;
                            busy_r      <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.cpu_safe) begin
                        pc_table_r[cur_idx_s] <= bus.cpu_pc_in;
`ifdef CTX_SAVE_REGS_EN
                        state_r   <= SAVE;
                        rf_addr_r <= 5'd0;
`else
                        state_r       <= RESUME;
                        pc_load_r     <= 1'b1;
                        switch_done_r <= 1'b1;
                        pc_value_r    <= pc_table_r[tgt_idx_s];
`endif
                    end
                end
`ifdef CTX_SAVE_REGS_EN
                SAVE: begin
                    if (rf_addr_r == LAST_REG) begin
                        state_r    <= LOAD;
                        rf_addr_r  <= 5'd0;
                        rf_we_r    <= 1'b1;
                        rf_wdata_r <= ctx_r[tgt_idx_s][REG_W'(0)];
                    end else begin
                        rf_addr_r <= next_addr_s;
                    end
                end
                LOAD: begin
                    if (rf_addr_r == LAST_REG) begin
                        state_r       <= RESUME;
                        rf_addr_r     <= 5'd0;
                        rf_we_r       <= 1'b0;
                        rf_wdata_r    <= 32'd0;
                        pc_load_r     <= 1'b1;
                        switch_done_r <= 1'b1;
                        pc_value_r    <= pc_table_r[tgt_idx_s];
                    end else begin
                        rf_addr_r  <= next_addr_s;
                        rf_wdata_r <= ctx_r[tgt_idx_s][next_addr_s[REG_W-1:0]];
                    end
                end
`endif
                RESUME: begin
                    current_pid_r <= target_r;
                    state_r       <= IDLE;
                    cpu_stall_r   <= 1'b0;
                    busy_r        <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    cpu_stall_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_stall   = cpu_stall_r;
    assign bus.busy        = busy_r;
    assign bus.pc_load     = pc_load_r;
    assign bus.pc_value    = pc_value_r;
    assign bus.current_pid = current_pid_r;
    assign bus.switch_done = switch_done_r;
    assign bus.err         = err_r;
endmodule

// File: tb/tb_context_switch_unit.sv
// Directed bench for context_switch_unit (NPROC=5, NREGS=8). A small CPU
// register file model answers reads; every switch request pushes its expected
// outcome to a queue that is popped when the unit signals completion.
// Expectations follow CTX_SAVE_REGS_EN the same way the design does.
module tb_context_switch_unit;
    localparam int NPROC = 5;
    localparam int NREGS = 8;
`ifdef CTX_SAVE_REGS_EN
    localparam int STALL      = 2 * NREGS + 2;
    localparam int NWR        = NREGS;
    localparam int LOAD_TICKS = 10;
`else
    localparam int STALL      = 2;
    localparam int NWR        = 0;
    localparam int LOAD_TICKS = 0;
`endif
    localparam int K_SW   = 0;
    localparam int K_SAME = 1;
    localparam int K_ERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] pc;
        int          stall;
        int          nwr;
        bit          chk_data;
        logic [31:0] base;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    context_switch_unit_if bus ();

    context_switch_unit #(
        .NPROC    (NPROC),
        .NREGS    (NREGS),
        .PC_STRIDE(32'd256)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] tb_rf [0:31];
    logic        pre_go = 1'b0;
    logic [31:0] pre_base = 32'd0;

    assign bus.rf_rdata = tb_rf[bus.rf_addr];

    // CPU register file model with a bulk preload for test setup
    always @(posedge clock) begin
        if (pre_go) begin
            for (int i = 0; i < 32; i++) tb_rf[i] <= pre_base + 32'(i);
        end else if (bus.rf_we) begin
            tb_rf[bus.rf_addr] <= bus.rf_wdata;
        end
    end

    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] exp_pc [0:NPROC-1];
    int          cur_m = 0;
    int          stall_cnt = 0;
    int          wr_idx = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NPROC; i++) exp_pc[i] = 32'(i) * 32'd256;
        cur_m = 0;
        exp_q.delete();
    endtask

    // Advance to the next falling edge and score whatever the unit produced
    task automatic tick();
        exp_t e;
        @(negedge clock);
        if (reset) begin
            stall_cnt = 0;
            wr_idx = 0;
        end else begin
            if (bus.cpu_stall) stall_cnt++;
            if (bus.rf_we) begin
                check("wr_addr", {27'd0, bus.rf_addr}, 32'(wr_idx));
                if (exp_q.size() > 0 && exp_q[0].chk_data)
                    check("wr_data", bus.rf_wdata, exp_q[0].base + 32'(wr_idx));
                wr_idx++;
            end
            if (bus.pc_load || bus.switch_done || bus.err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {29'd0, bus.pc_load, bus.switch_done, bus.err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind == K_SW) begin
                        check("sw_pc_load", {31'd0, bus.pc_load}, 32'd1);
                        check("sw_done", {31'd0, bus.switch_done}, 32'd1);
                        check("sw_err", {31'd0, bus.err}, 32'd0);
                        check("sw_pc_value", bus.pc_value, e.pc);
                        check("sw_stall_len", 32'(stall_cnt), 32'(e.stall));
                        check("sw_writes", 32'(wr_idx), 32'(e.nwr));
                    end else if (e.kind == K_SAME) begin
                        check("same_done", {31'd0, bus.switch_done}, 32'd1);
                        check("same_pc_load", {31'd0, bus.pc_load}, 32'd0);
                        check("same_stall", 32'(stall_cnt), 32'd0);
                    end else begin
                        check("err_pulse", {31'd0, bus.err}, 32'd1);
                        check("err_no_done", {30'd0, bus.switch_done, bus.pc_load}, 32'd0);
                        check("err_stall", 32'(stall_cnt), 32'd0);
                    end
                end
                stall_cnt = 0;
                wr_idx = 0;
            end
        end
    endtask

    task automatic expect_sw(input int pid, input int extra, input bit chk, input logic [31:0] base);
        exp_t e;
        e.kind = K_SW; e.pc = exp_pc[pid]; e.stall = STALL + extra;
        e.nwr = NWR; e.chk_data = chk; e.base = base;
        exp_q.push_back(e);
        exp_pc[cur_m] = bus.cpu_pc_in;
        cur_m = pid;
    endtask

    task automatic expect_kind(input int kind);
        exp_t e;
        e.kind = kind; e.pc = 32'd0; e.stall = 0; e.nwr = 0; e.chk_data = 1'b0; e.base = 32'd0;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [31:0] pid);
        bus.switch_req = 1'b1;
        bus.next_pid = pid;
        tick();
        bus.switch_req = 1'b0;
    endtask

    task automatic preload(input logic [31:0] base);
        pre_base = base;
        pre_go = 1'b1;
        tick();
        pre_go = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check("completion_timeout", 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.switch_req = 1'b0;
        bus.next_pid = 32'd0;
        bus.cpu_safe = 1'b1;
        bus.cpu_pc_in = 32'h40;
        reset_model();
        tick();
        tick();
        check("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_pid", bus.current_pid, 32'd0);
        check("rst_rf", {bus.rf_we, bus.rf_addr, bus.rf_wdata[25:0]}, 32'd0);
        check("rst_pulses", {29'd0, bus.pc_load, bus.switch_done, bus.err}, 32'd0);
        check("rst_pc_value", bus.pc_value, 32'd0);
        reset = 1'b0;
        tick();

        // 1: pid 0 -> 1, pid 0 registers hold 0xA0..
        preload(32'hA0);
        expect_sw(1, 0, 1'b0, 32'd0);
        send(32'd1);
        wait_idle();
        check("t1_pid", bus.current_pid, 32'd1);
        check("t1_stall_off", {31'd0, bus.cpu_stall}, 32'd0);
        check("t1_busy_off", {31'd0, bus.busy}, 32'd0);

        // 2: back to pid 0 restores its registers and PC 0x40
        preload(32'hB0);
        bus.cpu_pc_in = 32'h0000_0800;
        expect_sw(0, 0, 1'b1, 32'hA0);
        send(32'd0);
        wait_idle();
        check("t2_pid", bus.current_pid, 32'd0);

        // 3: out-of-range pids and a switch to the running pid
        expect_kind(K_ERR);
        send(32'd7);
        wait_idle();
        expect_kind(K_ERR);
        send(32'd5);
        wait_idle();
        expect_kind(K_ERR);
        send(32'h8000_0001);
        wait_idle();
        check("t3_pid", bus.current_pid, 32'd0);
        expect_kind(K_SAME);
        send(32'd0);
        wait_idle();
        check("t3_same_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("t3_same_pid", bus.current_pid, 32'd0);

        // 4: two requests while busy; only the latest (pid 3) runs afterwards
        bus.cpu_pc_in = 32'h0000_1000;
        expect_sw(1, 0, 1'b0, 32'd0);
        send(32'd1);
`ifdef CTX_SAVE_REGS_EN
        tick();
`endif
        send(32'd2);
        expect_sw(3, 0, 1'b0, 32'd0);
        send(32'd3);
        wait_idle();
        check("t4_pid", bus.current_pid, 32'd3);
        check("t4_busy_off", {31'd0, bus.busy}, 32'd0);

        // 5: CPU not safe for 10 cycles; PC captured only when it rises
        bus.cpu_safe = 1'b0;
        bus.cpu_pc_in = 32'hDEAD_0000;
        expect_sw(4, 10, 1'b0, 32'd0);
        exp_pc[3] = 32'h0000_5550;
        send(32'd4);
        for (int k = 0; k < 10; k++) begin
            check("t5_drain_stall", {31'd0, bus.cpu_stall}, 32'd1);
            check("t5_drain_quiet", {26'd0, bus.rf_we, bus.rf_addr}, 32'd0);
            tick();
        end
        bus.cpu_safe = 1'b1;
        bus.cpu_pc_in = 32'h0000_5550;
        wait_idle();
        check("t5_pid", bus.current_pid, 32'd4);
        expect_sw(3, 0, 1'b0, 32'd0);
        send(32'd3);
        wait_idle();
        check("t5_back_pid", bus.current_pid, 32'd3);

        // 6: reset in the middle of a switch
        send(32'd1);
        for (int k = 0; k < LOAD_TICKS; k++) tick();
        check("t6_mid_stall", {31'd0, bus.cpu_stall}, 32'd1);
`ifdef CTX_SAVE_REGS_EN
        check("t6_in_load", {31'd0, bus.rf_we}, 32'd1);
`endif
        reset = 1'b1;
        #1;
        check("t6_rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check("t6_rst_we", {31'd0, bus.rf_we}, 32'd0);
        check("t6_rst_pid", bus.current_pid, 32'd0);
        check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        reset = 1'b0;
        reset_model();
        tick();
        expect_sw(1, 0, 1'b0, 32'd0);
        send(32'd1);
        wait_idle();
        check("t6_pid", bus.current_pid, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
